// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, select codes, state encoding and helpers for alu_sequencer
//
// Contents:
//   ADD..BXR        3-bit ALU opcodes presented on OP
//   SEL_*           4-bit datapath module select codes
//   state_t         sequencer state encoding
//   is_unary()      true for opcodes that only use ACC (DEC, INC, OC)
package alu_seq_pkg;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] DEC = 3'b010;
    localparam logic [2:0] INC = 3'b011;
    localparam logic [2:0] OC  = 3'b100;
    localparam logic [2:0] BND = 3'b101;
    localparam logic [2:0] BOR = 3'b110;
    localparam logic [2:0] BXR = 3'b111;

    localparam logic [3:0] SEL_IDLE = 4'b0000;
    localparam logic [3:0] SEL_ACC  = 4'b0001;
    localparam logic [3:0] SEL_BREG = 4'b0010;
    localparam logic [3:0] SEL_ALU  = 4'b0011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic logic is_unary(input logic [2:0] op);
        return (op == DEC) || (op == INC) || (op == OC);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command-driven sequencer for the ACC/BREG/ALU datapath
//
// Accepts one command on CMD_VALID/CMD_READY, loads ACC and BREG over BUS_DRV,
// enables the ALU onto the bus for ALU_LAT cycles, captures BUS_IN and returns
// it on RES_VALID/RES_READY.
//
// Ports:
//   CLK, RESET                   clock, synchronous active-high reset
//   CMD_VALID/READY, CMD_OP,
//   CMD_A, CMD_B, CMD_USE_ACC    command channel
//   SEL, PRGM, OE, OP, BUS_DRV   registered datapath controls
//   BUS_IN                       datapath bus (ALU result)
//   RES_VALID/READY, RES_DATA,
//   RES_ZERO                     result channel
//   BUSY                         sequencer not idle
//
// Build option: ALU_SEQ_WRITEBACK_EN adds a WB state that writes the result
// back into ACC so CMD_USE_ACC chains results.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [2:0]        CMD_OP,
    input  logic [DATA_W-1:0] CMD_A,
    input  logic [DATA_W-1:0] CMD_B,
    input  logic              CMD_USE_ACC,
    output logic [3:0]        SEL,
    output logic              PRGM,
    output logic              OE,
    output logic [2:0]        OP,
    output logic [DATA_W-1:0] BUS_DRV,
    input  logic [DATA_W-1:0] BUS_IN,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [DATA_W-1:0] RES_DATA,
    output logic              RES_ZERO,
    output logic              BUSY
);

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t            state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] b_q;
    logic [3:0]        exec_cnt;
    logic              acc_valid;

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            op_q      <= '0;
            b_q       <= '0;
            exec_cnt  <= '0;
            acc_valid <= 1'b0;
            SEL       <= SEL_IDLE;
            PRGM      <= 1'b0;
            OE        <= 1'b0;
            OP        <= '0;
            BUS_DRV   <= '0;
            RES_VALID <= 1'b0;
            RES_DATA  <= '0;
            RES_ZERO  <= 1'b0;
        end else begin
            // Controls fall back to idle unless the next state drives them,
            // which also guarantees PRGM and OE never overlap.
            SEL     <= SEL_IDLE;
            PRGM    <= 1'b0;
            OE      <= 1'b0;
            OP      <= '0;
            BUS_DRV <= '0;

            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        op_q <= CMD_OP;
                        b_q  <= CMD_B;
                        // A reuse request against an unloaded ACC is a normal load.
                        if (!(CMD_USE_ACC && acc_valid)) begin
                            state     <= LOAD_A;
                            SEL       <= SEL_ACC;
                            PRGM      <= 1'b1;
                            BUS_DRV   <= CMD_A;
                            acc_valid <= 1'b1;
                        end else if (!is_unary(CMD_OP)) begin
                            state   <= LOAD_B;
                            SEL     <= SEL_BREG;
                            PRGM    <= 1'b1;
                            BUS_DRV <= CMD_B;
                        end else begin
                            state    <= EXEC;
                            SEL      <= SEL_ALU;
                            OP       <= CMD_OP;
                            OE       <= 1'b1;
                            exec_cnt <= LAT_M1;
                        end
                    end
                end

                LOAD_A: begin
                    if (is_unary(op_q)) begin
                        state    <= EXEC;
                        SEL      <= SEL_ALU;
                        OP       <= op_q;
                        OE       <= 1'b1;
                        exec_cnt <= LAT_M1;
                    end else begin
                        state   <= LOAD_B;
                        SEL     <= SEL_BREG;
                        PRGM    <= 1'b1;
                        BUS_DRV <= b_q;
                    end
                end

                LOAD_B: begin
                    state    <= EXEC;
                    SEL      <= SEL_ALU;
                    OP       <= op_q;
                    OE       <= 1'b1;
                    exec_cnt <= LAT_M1;
                end

                EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        RES_DATA <= BUS_IN;
                        RES_ZERO <= (BUS_IN == '0);
`ifdef ALU_SEQ_WRITEBACK_EN
                        state   <= WB;
                        SEL     <= SEL_ACC;
                        PRGM    <= 1'b1;
                        BUS_DRV <= BUS_IN;
`else
                        state     <= DONE;
                        RES_VALID <= 1'b1;
`endif
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                        SEL      <= SEL_ALU;
                        OP       <= op_q;
                        OE       <= 1'b1;
                    end
                end

                WB: begin
                    state     <= DONE;
                    RES_VALID <= 1'b1;
                end

                DONE: begin
                    if (RES_READY) begin
                        state     <= IDLE;
                        RES_VALID <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Controller that sequences the 8-bit ACC / BREG / ALU datapath for a single requester.
- Takes one command (opcode plus operands) over a valid/ready handshake.
- Loads ACC, then BREG, then enables ALU output onto the bus and captures the result.
- Returns the result on a second valid/ready handshake.
- Replaces manual SEL/PRGM/OE toggling from the front panel or a bench.

Parameters:
DATA_W, 8, datapath/bus width
ALU_LAT, 1, cycles OE is held before BUS_IN is sampled; legal range 1..15

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  sequencer can accept a command
CMD_OP  in  3  ALU opcode: ADD 000, SUB 001, DEC 010, INC 011, OC 100, BND 101, BOR 110, BXR 111
CMD_A  in  DATA_W  operand for ACC
CMD_B  in  DATA_W  operand for BREG; ignored for unary ops
CMD_USE_ACC  in  1  skip the ACC load and reuse the current ACC contents
SEL  out  4  datapath module select: ACC 0001, BREG 0010, ALU 0011, idle 0000
PRGM  out  1  write BUS_DRV into the selected register
OE  out  1  ALU output enable onto the bus
OP  out  3  opcode presented to the ALU
BUS_DRV  out  DATA_W  program data toward the datapath
BUS_IN  in  DATA_W  datapath bus (ALU result)
RES_VALID  out  1  result available
RES_READY  in  1  consumer accepts the result
RES_DATA  out  DATA_W  captured result
RES_ZERO  out  1  RES_DATA == 0
BUSY  out  1  state != IDLE

Behaviour:
- Reset (synchronous, highest priority, honoured in any state):
  - state = IDLE.
  - SEL, PRGM, OE, OP, BUS_DRV, RES_DATA, RES_ZERO, RES_VALID, BUSY all 0.
  - acc_valid = 0.
- States:
  - IDLE: CMD_READY = 1. On CMD_VALID & CMD_READY, latch op/A/B/use_acc, then branch:
    - LOAD_A if !(use_acc & acc_valid).
    - Else LOAD_B for a binary op.
    - Else EXEC for a unary op.
  - LOAD_A (1 cycle): SEL = ACC, PRGM = 1, BUS_DRV = A; set acc_valid. Next is LOAD_B for a binary op, EXEC for a unary op.
  - LOAD_B (1 cycle): SEL = BREG, PRGM = 1, BUS_DRV = B. Next is EXEC.
  - EXEC (ALU_LAT cycles, down-counter): SEL = ALU, OP = op, OE = 1, PRGM = 0. At the end of the last cycle, sample BUS_IN into RES_DATA and compute RES_ZERO. Next is WB (when the feature is enabled) or DONE.
  - DONE: RES_VALID = 1; RES_DATA and RES_ZERO held stable. On RES_READY go to IDLE.
- Unary ops: DEC, INC, OC. They never enter LOAD_B.
- Registered control outputs:
  - PRGM and OE are never high in the same cycle.
  - Outside the states above, SEL/OP/BUS_DRV return to 0.
- Latency from the accept edge to RES_VALID high, ALU_LAT = 1:
  - binary op: 3 cycles
  - unary op: 2 cycles
  - binary op with USE_ACC hit: 2 cycles
  - unary op with USE_ACC hit: 1 cycle
  - ALU_LAT > 1 adds ALU_LAT - 1 cycles.
- Handshake rules:
  - CMD_READY is 0 outside IDLE.
  - If RES_VALID & RES_READY occur in the same cycle, the next command can be accepted the following cycle; there is no same-cycle overlap.
  - RES_VALID stays high indefinitely under backpressure.
- CMD_USE_ACC with acc_valid = 0 is silently treated as 0.
- Width rules: no carry/borrow output; the result is whatever the datapath drives, modulo 2^DATA_W.
- Reset mid-operation: the command is abandoned and no result is returned. The datapath registers keep whatever was already written, but acc_valid is cleared.

Optional Feature:
ALU_SEQ_WRITEBACK_EN
- Defined:
  - After EXEC, a WB state (1 cycle) drives SEL = ACC, PRGM = 1, BUS_DRV = captured result.
  - ACC then holds the result, so CMD_USE_ACC chains the previous result.
  - Adds 1 cycle of latency.
- Undefined:
  - No WB state; ACC keeps the last loaded A.
  - CMD_USE_ACC reuses the previous A operand.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants ADD..BXR
  - SEL codes SEL_IDLE/SEL_ACC/SEL_BREG/SEL_ALU
  - state enum IDLE/LOAD_A/LOAD_B/EXEC/WB/DONE
  - is_unary(op) function
- No sub-module. The ALU_LAT counter and the FSM stay inline in alu_sequencer.

Test Plan:
- The bench models the datapath: ACC/BREG written on PRGM, BUS_IN = ALU(ACC, BREG, OP) when OE = 1.
1. A = 0xAA, B = 0x55, ADD -> SEL sequence 1, 2, 3; RES_DATA = 0xFF, RES_ZERO = 0; RES_VALID 3 cycles after accept.
2. A = 0xAA, B = 0x55, SUB -> 0x55. Then BND -> 0x00 with RES_ZERO = 1. Then BXR -> 0xFF.
3. A = 0xFF, INC -> no SEL = 0010 cycle; RES_DATA = 0x00, RES_ZERO = 1; latency 2. OC with A = 0x0F -> 0xF0.
4. RES_READY held low 5 cycles -> RES_VALID/RES_DATA stable and CMD_READY = 0 throughout. Release -> IDLE next cycle; a new command is accepted the cycle after.
5. RESET asserted during LOAD_B -> next cycle all outputs 0, IDLE. A following USE_ACC = 1 DEC command still performs LOAD_A (acc_valid cleared).
6. USE_ACC chain: 0x10 ADD 0x01, then USE_ACC ADD 0x01.
   - Without ALU_SEQ_WRITEBACK_EN: 0x11 then 0x11.
   - With it: 0x11 then 0x12, and latency +1.
